// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// State encoding, key map and active-low row decoding.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } scan_state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Map a (row, column) position to the legend printed on the key.
    function automatic logic [3:0] key_decode(
        input logic [1:0] row_idx,
        input logic [1:0] col_idx
    );
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // True when exactly one active-low row is asserted.
    function automatic logic single_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) ||
               (v == 4'b1011) || (v == 4'b0111);
    endfunction

    // Index of the lowest asserted (low) row; only meaningful
    // when single_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else if (!v[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all ones so idle pulled-up lines read inactive.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values: plain two-stage shift.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, preset to idle-high on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Emits one validated hex code per press and a two-digit history.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] rows_s;

    scan_state_t    state_d, state_q;
    logic [1:0]     col_d, col_q;
    logic [1:0]     row_idx_d, row_idx_q;
    logic [DW-1:0]  dwell_d, dwell_q;
    logic [BW-1:0]  db_d, db_q;
    logic [3:0]     key_code_d, key_code_q;
    logic           key_valid_d, key_valid_q;
    logic           key_held_d, key_held_q;
    logic [3:0]     digit_new_d, digit_new_q;
    logic [3:0]     digit_old_d, digit_old_q;

    logic           row_low;
    logic [3:0]     hit_code;

    sync2 #(
        .WIDTH (4)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    assign row_low  = ~rows_s[row_idx_q];
    assign hit_code = key_decode(row_idx_q, col_q);

    // Drive the current column low, all others released.
    always_comb begin
        cols = 4'b1111;
        cols[col_q] = 1'b0;
    end

    // Scan/debounce sequencing and output updates.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_idx_d   = row_idx_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;

        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (single_low(rows_s)) begin
                        row_idx_d = low_index(rows_s);
                        db_d      = '0;
                        state_d   = DB_PRESS;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DB_PRESS: begin
                if (db_q == DB_LAST) begin
                    db_d    = '0;
                    dwell_d = '0;
                    if (row_low) begin
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        key_code_d  = hit_code;
                        digit_old_d = digit_new_q;
                        digit_new_d = hit_code;
                        state_d     = HELD;
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end else begin
                    db_d = db_q + BW'(1);
                end
            end
            HELD: begin
                if (!row_low) begin
                    db_d    = '0;
                    state_d = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (db_q == DB_LAST) begin
                    db_d = '0;
                    if (!row_low) begin
                        dwell_d    = '0;
                        col_d      = col_q + 2'd1;
                        key_held_d = 1'b0;
                        state_d    = SCAN;
                    end else begin
                        state_d = HELD;
                    end
                end else begin
                    db_d = db_q + BW'(1);
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State and output registers; reset forces a fresh scan at column 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_idx_q   <= 2'd0;
            dwell_q     <= '0;
            db_q        <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix model drives rows from cols,
// expected codes go through a queue checked on each key_valid.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DBC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    logic [3:0]  m_new, m_old, pop_e;
    logic        prev_v;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_pulse = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DBC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    // Passive matrix: a pressed key pulls its row low when its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c])
                    rows[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Scoreboard: every key_valid pops one expected code.
    always @(negedge clk) begin
        if (key_valid) begin
            n_pulse++;
            chk("pulse_w", {31'd0, prev_v}, 0);
            if (exp_q.size() == 0) begin
                chk("unexp_valid", 1, 0);
            end else begin
                pop_e = exp_q.pop_front();
                m_old = m_new;
                m_new = pop_e;
                chk("sb_code", {28'd0, key_code}, {28'd0, pop_e});
                chk("sb_new", {28'd0, digit_new}, {28'd0, m_new});
                chk("sb_old", {28'd0, digit_old}, {28'd0, m_old});
            end
        end
        prev_v = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for a fresh arrival of column pattern v.
    task automatic wait_col(input logic [3:0] v, input string tag,
                            output int k);
        k = 0;
        while (cols == v && k < 100) begin
            @(negedge clk);
            k++;
        end
        while (cols != v && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100)
            chk(tag, {28'd0, cols}, {28'd0, v});
    endtask

    task automatic wait_pulse(input int target, input string tag);
        int k;
        k = 0;
        while (n_pulse < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_pulse, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        logic [3:0] seen;
        logic held_ok;

        keys   = '0;
        reset  = 1'b1;
        m_new  = 4'h0;
        m_old  = 4'h0;
        prev_v = 1'b0;
        tick(3);
        chk("rst_cols", {28'd0, cols}, 32'hE);
        chk("rst_code", {28'd0, key_code}, 0);
        chk("rst_valid", {31'd0, key_valid}, 0);
        chk("rst_held", {31'd0, key_held}, 0);
        chk("rst_new", {28'd0, digit_new}, 0);
        chk("rst_old", {28'd0, digit_old}, 0);
        reset = 1'b0;

        // Clean press of key 6 (row 1, column 2).
        base = n_pulse;
        wait_col(4'b1011, "to_c2", k);
        keys[1*4+2] = 1'b1;
        exp_q.push_back(4'h6);
        tick(40);
        chk("clean_n", n_pulse, base + 1);
        chk("clean_cols", {28'd0, cols}, 32'hB);
        chk("clean_held", {31'd0, key_held}, 1);
        chk("clean_code", {28'd0, key_code}, 6);

        // Reset while held.
        reset = 1'b1;
        #1;
        chk("rh_cols", {28'd0, cols}, 32'hE);
        chk("rh_held", {31'd0, key_held}, 0);
        chk("rh_code", {28'd0, key_code}, 0);
        chk("rh_new", {28'd0, digit_new}, 0);
        chk("rh_old", {28'd0, digit_old}, 0);
        m_new = 4'h0;
        m_old = 4'h0;
        exp_q.delete();
        @(negedge clk);
        keys  = '0;
        reset = 1'b0;
        tick(3);
        chk("rh_c0", {28'd0, cols}, 32'hE);
        tick(1);
        chk("rh_c1", {28'd0, cols}, 32'hD);

        // Bounce on key 1: short press must not validate.
        base = n_pulse;
        wait_col(4'b1110, "to_c0", k);
        keys[0] = 1'b1;
        tick(5);
        keys[0] = 1'b0;
        wait_col(4'b1101, "bnc_wait", k);
        chk("bnc_col", {28'd0, cols}, 32'hD);
        chk("bnc_frz", {31'd0, (k >= 10)}, 1);
        tick(10);
        chk("bnc_n", n_pulse, base);

        // Two presses: 5 then D.
        base = n_pulse;
        wait_col(4'b1101, "to_c1", k);
        keys[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_pulse(base + 1, "p5_pulse");
        tick(3);
        keys = '0;
        tick(25);
        chk("p5_rel", {31'd0, key_held}, 0);
        wait_col(4'b0111, "to_c3", k);
        keys[3*4+3] = 1'b1;
        exp_q.push_back(4'hD);
        wait_pulse(base + 2, "pd_pulse");
        tick(3);
        keys = '0;
        tick(25);
        chk("two_n", n_pulse, base + 2);
        chk("two_old", {28'd0, digit_old}, 5);
        chk("two_new", {28'd0, digit_new}, 32'hD);

        // Two keys on one column are ignored.
        base = n_pulse;
        wait_col(4'b1101, "mk_c1", k);
        keys[0*4+1] = 1'b1;
        keys[2*4+1] = 1'b1;
        seen = 4'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | ~cols;
        end
        chk("mk_none", n_pulse, base);
        chk("mk_scan", {28'd0, seen}, 32'hF);
        keys = '0;
        tick(8);

        // Key 2 held, key 8 added, then 2 released.
        wait_col(4'b1101, "mk2_c1", k);
        keys[0*4+1] = 1'b1;
        exp_q.push_back(4'h2);
        wait_pulse(base + 1, "mk2_pulse");
        tick(2);
        keys[2*4+1] = 1'b1;
        tick(30);
        chk("mk_held_n", n_pulse, base + 1);
        chk("mk_held", {31'd0, key_held}, 1);
        chk("mk_cols", {28'd0, cols}, 32'hD);
        keys[0*4+1] = 1'b0;
        exp_q.push_back(4'h8);
        wait_pulse(base + 2, "mk8_pulse");
        tick(5);
        chk("mk8_n", n_pulse, base + 2);
        keys = '0;
        tick(25);

        // Release bounce on key 9.
        base = n_pulse;
        wait_col(4'b1011, "rb_c2", k);
        keys[2*4+2] = 1'b1;
        exp_q.push_back(4'h9);
        wait_pulse(base + 1, "rb_pulse");
        tick(3);
        keys[2*4+2] = 1'b0;
        tick(6);
        keys[2*4+2] = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            held_ok = held_ok & key_held;
        end
        chk("rb_held", {31'd0, held_ok}, 1);
        chk("rb_n", n_pulse, base + 1);
        chk("rb_cols", {28'd0, cols}, 32'hB);
        keys = '0;
        tick(25);
        chk("rb_rel", {31'd0, key_held}, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scan controller for the 4x4 matrix keypad. It drives the columns one at a time, samples the synchronized rows, and locks onto a single pressed key. It sequences press and release debounce intervals, then emits one validated hex code per press plus a two-digit history for the seven-segment display driver. It sits between the keypad pins and the display multiplexer, replacing free-running debounce on a raw key-pressed line.

## Interface
- `SCAN_DIV`, default 48000: clock cycles each column is driven (1 ms at 48 MHz); minimum 4.
- `DEBOUNCE_CYCLES`, default 960000: debounce interval in cycles (20 ms at 48 MHz); minimum 2.
- `clk`  in  1  system clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `rows`  in  4  raw keypad rows, active-low with pull-ups, asynchronous to `clk`.
- `cols`  out  4  column drive, active-low; exactly one bit low at all times.
- `key_code`  out  4  hex value of the last validated key.
- `key_valid`  out  1  one-cycle pulse when a new key is validated.
- `key_held`  out  1  high while the validated key remains pressed (`HELD`/`DB_RELEASE`).
- `digit_new`  out  4  most recent key code.
- `digit_old`  out  4  previous key code.

## Operation
- Rows pass through a 2-flop synchronizer; all decisions use the synchronized value `rows_s`.
- The states are `SCAN`, `DB_PRESS`, `HELD` and `DB_RELEASE`.
- `SCAN`:
  - The dwell counter runs from 0 to `SCAN_DIV-1` on the current column.
  - On the last dwell cycle, `rows_s` is sampled.
  - If exactly one bit is low, latch the row index and column index, keep the column frozen, and go to `DB_PRESS`.
  - If zero bits or more than one bit are low, rotate to the next column (3 wraps to 0) and restart the dwell.
- `DB_PRESS`:
  - The debounce counter starts at 0 on entry.
  - At count `DEBOUNCE_CYCLES-1`, check the latched row.
  - If it is still low: pulse `key_valid`, load `key_code`, shift `digit_old`←`digit_new` and `digit_new`←code, then go to `HELD`.
  - If it is high: go to `SCAN` on the next column with no output change.
- `HELD`:
  - The column stays frozen, and all other rows and columns are ignored, including a second simultaneous key.
  - When the latched row reads high, go to `DB_RELEASE`.
- `DB_RELEASE`:
  - The counter restarts at 0.
  - At count `DEBOUNCE_CYCLES-1`: if the latched row is high, go to `SCAN` (next column); if it is low again, return to `HELD` with no new `key_valid`.
- Key map, indexed by row then columns 0..3:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E, 0, F, D
- Counter widths are `$clog2(SCAN_DIV)` and `$clog2(DEBOUNCE_CYCLES)`. Counters never wrap mid-interval; they are cleared on every state entry.

## Timing
- Values while `reset` is high:
  - `cols`=4'b1110 (column 0), state `SCAN`, both counters 0.
  - `key_code`=0, `key_valid`=0, `key_held`=0, `digit_new`=0, `digit_old`=0.
  - Synchronizer flops are set to 4'b1111.
- Reset deasserted mid-debounce or while held: the FSM restarts in `SCAN`, column 0, and no pulse is emitted.
- Input latency: a `rows` edge reaches `rows_s` 2 cycles later.
- `key_valid` rises on the cycle after the `DB_PRESS` terminal count and is high exactly 1 cycle. `key_code` and both digits update on that same edge.
- `key_held` is registered: high from the `key_valid` cycle until the cycle after `DB_RELEASE` exits to `SCAN`.
- Column rotation takes effect on the cycle after the last dwell cycle, so each column is driven exactly `SCAN_DIV` cycles.
- Worst-case detection latency is 4·`SCAN_DIV` + 2 + `DEBOUNCE_CYCLES` + 1 cycles.

## Structure
- Package `keypad_pkg`:
  - `scan_state_t` enum (`SCAN`, `DB_PRESS`, `HELD`, `DB_RELEASE`).
  - Key-map function `key_decode(row_idx, col_idx)` returning a 4-bit code.
  - One-hot-to-index helper plus single-bit-low check.
- Sub-module `sync2`: 2-flop synchronizer, parameterized width, async-high reset to all ones. Everything else stays in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=16.
- Reset: assert mid-`HELD` → `cols`=4'b1110, all outputs 0 within the same cycle; after release, the scan restarts at column 0.
- Clean press: row 1 low while column 2 is driven, held 40 cycles → exactly one `key_valid`, `key_code`=6, `digit_new`=6, `digit_old`=0, `cols` frozen at 4'b1011.
- Bounce: row 0 low for 5 cycles on column 0, then high → no `key_valid`, and the scan resumes on column 1.
- Two presses: key 5, release, then key D → `digit_old`=5, `digit_new`=D; exactly two `key_valid` pulses.
- Multi-key: rows 0 and 2 low together on column 1 → ignored and scanning continues. With key 2 held, adding key 8 → no second pulse; releasing 2 resumes scanning, after which 8 is validated once.
- Release bounce: in `HELD`, the row goes high for 6 cycles and then low again → return to `HELD`, no new `key_valid`, and `key_held` stays 1.
